// File: rtl/ibex_mem_responder.sv
// Ibex req/gnt/rvalid memory responder: word array with a configurable grant stall,
// fixed response latency and a bounded number of granted-but-unanswered transactions.
module ibex_mem_responder #(
    parameter int unsigned Depth          = 16384,
    parameter logic [31:0] AddrBase       = 32'h0010_0000,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int unsigned IdxW = $clog2(Depth);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (byte_en[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]            mem_r [Depth];
    logic [2:0]             cnt_r;
    logic [2:0]             inflight_r;
    logic [RespLatency-1:0] pipe_valid_r;
    logic [RespLatency-1:0] pipe_err_r;
    logic [31:0]            pipe_data_r [RespLatency];

    logic                   in_range_s;
    logic [IdxW-1:0]        idx_s;
    logic                   delay_ok_s;
    logic                   slot_ok_s;
    logic                   unused_s;
    state_e                 state_s;

    // AddrBase is aligned to the array size, so the range check reduces to a tag compare.
    assign in_range_s = (addr_i[31:IdxW+2] == AddrBase[31:IdxW+2]);
    assign idx_s      = addr_i[IdxW+1:2];
    assign unused_s   = ^addr_i[1:0];

    assign delay_ok_s = (({1'b0, cnt_r} + 4'd1) > 4'(GntDelay));
    assign slot_ok_s  = (inflight_r < 3'(MaxOutstanding)) || rvalid_o;

    // Request state for this cycle; the grant is the GRANT state itself.
    always_comb begin
        state_s = ST_IDLE;
        if (!rst_sys_ni || !req_i) begin
            state_s = ST_IDLE;
        end else if (delay_ok_s && slot_ok_s) begin
            state_s = ST_GRANT;
        end else begin
            state_s = ST_STALL;
        end
    end

    assign gnt_o = (state_s == ST_GRANT);

    // Stall counter and in-flight transaction count.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            cnt_r      <= 3'd0;
            inflight_r <= 3'd0;
        end else begin
            if (!req_i || gnt_o) begin
                cnt_r <= 3'd0;
            end else if (cnt_r != 3'd7) begin
                cnt_r <= cnt_r + 3'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if (gnt_o && !rvalid_o) begin
                inflight_r <= inflight_r + 3'd1;
            end else if (!gnt_o && rvalid_o) begin
                inflight_r <= inflight_r - 3'd1;
            end else begin
                inflight_r <= inflight_r;
            end
        end
    end

    // Response pipeline: stage 0 is loaded at the grant edge, the last stage drives the outputs.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            pipe_valid_r <= {RespLatency{1'b0}};
            pipe_err_r   <= {RespLatency{1'b0}};
            for (int i = 0; i < int'(RespLatency); i++) begin
                pipe_data_r[i] <= 32'd0;
            end
        end else begin
            pipe_valid_r[0] <= gnt_o;
            pipe_err_r[0]   <= gnt_o & ~in_range_s;
            pipe_data_r[0]  <= (gnt_o && !we_i && in_range_s) ? mem_r[idx_s] : 32'd0;
            for (int i = 1; i < int'(RespLatency); i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_err_r[i]   <= pipe_err_r[i-1];
                pipe_data_r[i]  <= pipe_data_r[i-1];
            end
        end
    end

    // Array write; the array is deliberately left out of reset so granted writes survive it.
    always_ff @(posedge clk_sys_i) begin
        if (gnt_o && we_i && in_range_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wdata_i, be_i);
        end
    end

    assign rvalid_o = pipe_valid_r[RespLatency-1];
    assign err_o    = pipe_err_r[RespLatency-1];
    assign rdata_o  = pipe_data_r[RespLatency-1];

endmodule
